mp_add_sequencer: RTL and testbench



---
 rtl/mp_add_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mp_add_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mp_add_sequencer.sv
// -----------------------------------------------------------------------------
// mp_add_sequencer
//
// Adds or subtracts two WORDS x 64-bit operands by time-sharing one external
// combinational 64-bit adder, least-significant word first. The carry between
// words is held in an internal register. Subtraction is done as A + ~B + 1.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, sub        request pulse (accepted only when idle), 0=add 1=subtract
//   op_a, op_b        W-bit operands, sampled with an accepted start
//   busy, done        busy in RUN/DONE, one-cycle done pulse
//   result            W-bit sum/difference, valid from done onward
//   carry_out         final carry (for subtraction 1 = no borrow)
//   overflow          two's-complement overflow of the full W-bit operation
//   add_a/add_b/add_cin  drive the external adder (zero outside RUN)
//   add_s/add_cout       external adder results, same cycle
// -----------------------------------------------------------------------------
module mp_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sub,
   input  logic [64*WORDS-1:0]   op_a,
   input  logic [64*WORDS-1:0]   op_b,
   output logic                  busy,
   output logic                  done,
   output logic [64*WORDS-1:0]   result,
   output logic                  carry_out,
   output logic                  overflow,
   output logic [63:0]           add_a,
   output logic [63:0]           add_b,
   output logic                  add_cin,
   input  logic [63:0]           add_s,
   input  logic                  add_cout
);

   localparam int W  = 64 * WORDS;
   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            cy_q, cy_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    result_q, result_d;
   logic            carry_out_q, carry_out_d;
   logic            overflow_q, overflow_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [63:0]     add_a_s, add_b_s;
   logic            add_cin_s;

   // Bit offset of the word currently on the adder; concatenation keeps it exact.
   logic [IW+5:0]   word_lsb_s;
   assign word_lsb_s = {idx_q, 6'd0};

   // Next-state, datapath and adder-port logic.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      cy_d        = cy_q;
      idx_d       = idx_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      add_a_s     = 64'd0;
      add_b_s     = 64'd0;
      add_cin_s   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d         = op_a;
               // Subtraction: store ~B and seed the carry with 1.
               b_d         = sub ? ~op_b : op_b;
               cy_d        = sub;
               idx_d       = {IW{1'b0}};
               result_d    = {W{1'b0}};
               carry_out_d = 1'b0;
               overflow_d  = 1'b0;
               state_d     = S_RUN;
            end else begin
               state_d     = S_IDLE;
            end
         end
         S_RUN: begin
            add_a_s   = a_q[word_lsb_s +: 64];
            add_b_s   = b_q[word_lsb_s +: 64];
            add_cin_s = cy_q;
            result_d[word_lsb_s +: 64] = add_s;
            cy_d      = add_cout;
            if (idx_q == IDX_LAST) begin
               carry_out_d = add_cout;
               // Operand sign bits agree but the top result bit differs.
               overflow_d  = (a_q[W-1] == b_q[W-1]) & (add_s[63] != a_q[W-1]);
               idx_d       = {IW{1'b0}};
               state_d     = S_DONE;
            end else begin
               idx_d       = idx_q + IW'(1);
               state_d     = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= {W{1'b0}};
         b_q         <= {W{1'b0}};
         cy_q        <= 1'b0;
         idx_q       <= {IW{1'b0}};
         result_q    <= {W{1'b0}};
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cy_q        <= cy_d;
         idx_q       <= idx_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign add_a     = add_a_s;
   assign add_b     = add_b_s;
   assign add_cin   = add_cin_s;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mp_add_sequencer
//
// Directed bench for mp_add_sequencer with WORDS=4. The external 64-bit adder
// is modelled with a continuous assignment. Each operation checks latency,
// done pulse count, busy, adder port contents and the final results against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_mp_add_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 64 * WORDS;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          sub;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          carry_out;
   logic          overflow;
   logic [63:0]   add_a;
   logic [63:0]   add_b;
   logic          add_cin;
   logic [63:0]   add_s;
   logic          add_cout;

   int n_tests;
   int n_fail;

   mp_add_sequencer #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout)
   );

   // Combinational stand-in for the external 64-bit adder.
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One operation: start at a negedge, then watch 8 cycles after acceptance.
   // With spam set, start is held high with random operands through RUN/DONE.
   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic ec,
                        input logic eo, input bit spam);
      int lat;
      int ndone;
      logic [63:0] exp_b0;
      lat    = -1;
      ndone  = 0;
      exp_b0 = s ? ~b[63:0] : b[63:0];
      @(negedge clk);
      start = 1'b1; sub = s; op_a = a; op_b = b;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (spam && k <= 5) begin
            start = 1'b1;
            sub   = 1'($urandom_range(0, 1));
            op_a  = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
            op_b  = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            ndone++;
            if (lat < 0) lat = k;
         end
         if (k == 1) begin
            check({tag, ".busy_run"}, W'(busy), W'(1'b1));
            check({tag, ".add_a_w0"}, W'(add_a), W'(a[63:0]));
            check({tag, ".add_b_w0"}, W'(add_b), W'(exp_b0));
            check({tag, ".add_cin_w0"}, W'(add_cin), W'(s));
         end
         if (k == 6) begin
            check({tag, ".busy_idle"}, W'(busy), W'(1'b0));
            check({tag, ".add_a_idle"}, W'(add_a), {W{1'b0}});
         end
      end
      check({tag, ".latency"}, W'(lat), W'(WORDS + 1));
      check({tag, ".done_count"}, W'(ndone), W'(1));
      check({tag, ".result"}, result, er);
      check({tag, ".carry_out"}, W'(carry_out), W'(ec));
      check({tag, ".overflow"}, W'(overflow), W'(eo));
   endtask

   logic [W-1:0] all_ones;
   logic [W-1:0] msb_only;
   int           rst_done;

   // Directed stimulus sequence.
   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst_done = 0;
      all_ones = {W{1'b1}};
      msb_only = {1'b1, {(W-1){1'b0}}};
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = {W{1'b0}}; op_b = {W{1'b0}};
      repeat (3) @(negedge clk);

      check("rst.busy", W'(busy), W'(1'b0));
      check("rst.done", W'(done), W'(1'b0));
      check("rst.result", result, {W{1'b0}});
      check("rst.carry_out", W'(carry_out), W'(1'b0));
      check("rst.overflow", W'(overflow), W'(1'b0));
      check("rst.add_a", W'(add_a), {W{1'b0}});
      check("rst.add_b", W'(add_b), {W{1'b0}});
      check("rst.add_cin", W'(add_cin), W'(1'b0));
      rst_n = 1'b1;

      do_op("ripple", all_ones, W'(1), 1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0);
      do_op("word_bnd", W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0,
            {{(W-128){1'b0}}, 64'd1, 64'd0}, 1'b0, 1'b0, 1'b0);
      do_op("sub_borrow", {W{1'b0}}, W'(1), 1'b1, all_ones, 1'b0, 1'b0, 1'b0);
      do_op("sub_5_3", W'(5), W'(3), 1'b1, W'(2), 1'b1, 1'b0, 1'b0);
      do_op("ovf_add", ~msb_only, W'(1), 1'b0, msb_only, 1'b0, 1'b1, 1'b0);
      do_op("ovf_sub", msb_only, W'(1), 1'b1, ~msb_only, 1'b1, 1'b1, 1'b0);
      do_op("busy_ign", {4{64'h8000_0000_0000_0000}}, {4{64'h8000_0000_0000_0000}}, 1'b0,
            {64'd1, 64'd1, 64'd1, 64'd0}, 1'b1, 1'b1, 1'b1);

      // Reset in cycle 2 of RUN: everything clears and no done appears.
      @(negedge clk);
      start = 1'b1; sub = 1'b0; op_a = W'(1); op_b = W'(1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst.busy", W'(busy), W'(1'b0));
      check("midrst.done", W'(done), W'(1'b0));
      check("midrst.result", result, {W{1'b0}});
      check("midrst.carry_out", W'(carry_out), W'(1'b0));
      check("midrst.overflow", W'(overflow), W'(1'b0));
      check("midrst.add_a", W'(add_a), {W{1'b0}});
      check("midrst.add_cin", W'(add_cin), W'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done === 1'b1) rst_done++;
      end
      check("midrst.no_done", W'(rst_done), W'(0));
      check("midrst.idle", W'(busy), W'(1'b0));
      do_op("after_rst", W'(7), W'(8), 1'b0, W'(15), 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
